// File: rtl/sort_5_serial.sv
// Serial insertion sorter: accepts up to N words, keeps them sorted on arrival, then drains them in order.
// Define SORT_5_SERIAL_DESCEND_EN to drain largest-first instead of smallest-first.
module sort_5_serial #(
    parameter int unsigned N     = 5,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    input  logic             in_last_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    output logic             out_last_o,
    input  logic             out_ready_i
);

    localparam int unsigned CNT_W = $clog2(N + 1);
`ifdef SORT_5_SERIAL_DESCEND_EN
    localparam bit DESCEND = 1'b1;
`else
    localparam bit DESCEND = 1'b0;
`endif

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] arr_q [N];
    logic [WIDTH-1:0] arr_d [N];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ins_pos;
    logic [N-1:0]     before_c;
    logic             in_fire;
    logic             out_fire;

    assign in_fire  = in_valid_i && in_ready_o;
    assign out_fire = out_valid_o && out_ready_i;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: begin
                if (in_fire && (in_last_i || (cnt_q == CNT_W'(N - 1)))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_fire && out_last_o) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Handshake outputs decoded from registered state only
    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        out_last_o  = 1'b0;
        out_data_o  = arr_q[0];
        case (state_q)
            FILL:    in_ready_o = ~rst;
            DRAIN: begin
                out_valid_o = 1'b1;
                out_last_o  = (cnt_q == CNT_W'(1));
            end
            default: in_ready_o = 1'b0;
        endcase
    end

    // Occupied entries that must stay ahead of the new word; ties keep arrival order
    always_comb begin
        before_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            before_c[i] = (CNT_W'(i) < cnt_q) &&
                          (DESCEND ? (arr_q[i] >= in_data_i) : (arr_q[i] <= in_data_i));
        end
    end

    always_comb begin
        ins_pos = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (before_c[i]) begin
                ins_pos = ins_pos + CNT_W'(1);
            end
        end
    end

    // Insert-with-shift-up on accept, shift-down on drain
    always_comb begin
        arr_d = arr_q;
        cnt_d = cnt_q;
        if (in_fire) begin
            if (ins_pos == '0) begin
                arr_d[0] = in_data_i;
            end
            for (int unsigned i = 1; i < N; i++) begin
                if (CNT_W'(i) == ins_pos) begin
                    arr_d[i] = in_data_i;
                end else if ((CNT_W'(i) > ins_pos) && (CNT_W'(i) <= cnt_q)) begin
                    arr_d[i] = arr_q[i-1];
                end
            end
            cnt_d = cnt_q + CNT_W'(1);
        end else if (out_fire) begin
            for (int unsigned i = 0; i + 1 < N; i++) begin
                arr_d[i] = arr_q[i+1];
            end
            arr_d[N-1] = '0;
            cnt_d      = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                arr_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            arr_q <= arr_d;
        end
    end

endmodule

// File: tb/tb_sort_5_serial.sv
// Self-checking bench for sort_5_serial: queue/sort scoreboard checked every cycle plus directed literal sequences.
module tb_sort_5_serial;

    localparam int N = 5;
`ifdef SORT_5_SERIAL_DESCEND_EN
    localparam bit DESC = 1'b1;
`else
    localparam bit DESC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready_o;
    logic [31:0] out_data_o;
    logic        out_valid_o;
    logic        out_last_o;
    logic        out_ready;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [31:0] grp  [$];
    logic [31:0] outq [$];
    logic [31:0] cap_d [$];
    logic        cap_l [$];
    logic [31:0] wv  [8];
    logic [31:0] exv [8];
    logic        m_ready, m_valid, m_last;
    logic [31:0] tmp;

    sort_5_serial #(.N(5), .WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data_i  (in_data),
        .in_valid_i (in_valid),
        .in_last_i  (in_last),
        .in_ready_o (in_ready_o),
        .out_data_o (out_data_o),
        .out_valid_o(out_valid_o),
        .out_last_o (out_last_o),
        .out_ready_i(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: groups collected in arrival order, stably sorted when complete
    always @(negedge clk) begin
        if (chk_en) begin
            m_ready = !rst && (outq.size() == 0);
            m_valid = (outq.size() != 0);
            m_last  = (outq.size() == 1);
            chk("in_ready", 32'(in_ready_o), 32'(m_ready));
            chk("out_valid", 32'(out_valid_o), 32'(m_valid));
            chk("out_last", 32'(out_last_o), 32'(m_last));
            if (m_valid) chk("out_data", out_data_o, outq[0]);
            if (out_valid_o && out_ready) begin
                cap_d.push_back(out_data_o);
                cap_l.push_back(out_last_o);
            end
            if (rst) begin
                grp.delete();
                outq.delete();
            end else begin
                if (m_valid && out_ready) void'(outq.pop_front());
                if (in_valid && m_ready) begin
                    grp.push_back(in_data);
                    if (grp.size() == N || in_last) begin
                        for (int i = 0; i < grp.size(); i++) begin
                            for (int j = 0; j + 1 < grp.size() - i; j++) begin
                                if (DESC ? (grp[j] < grp[j+1]) : (grp[j] > grp[j+1])) begin
                                    tmp      = grp[j];
                                    grp[j]   = grp[j+1];
                                    grp[j+1] = tmp;
                                end
                            end
                        end
                        outq = grp;
                        grp.delete();
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w [8], input int n, input bit use_last);
        bit hs;
        int budget;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = w[i];
            in_last  = use_last && (i == n - 1);
            hs       = 1'b0;
            budget   = 0;
            while (!hs && budget < 50) begin
                @(negedge clk);
                hs = in_ready_o;
                budget++;
                tick();
            end
            if (!hs) chk("send_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain(input int n, input bit [4:0] pat);
        int c;
        c = 0;
        while (cap_d.size() < n && c < 200) begin
            out_ready = pat[c % 5];
            c++;
            tick();
        end
        out_ready = 1'b0;
        if (cap_d.size() < n) chk("drain_timeout", 32'(cap_d.size()), 32'(n));
    endtask

    task automatic check_seq(input string name, input logic [31:0] e [8], input int n);
        chk({name, "_len"}, 32'(cap_d.size()), 32'(n));
        for (int i = 0; i < n && i < cap_d.size(); i++) begin
            chk(name, cap_d[i], e[i]);
        end
    endtask

    task automatic clear_cap();
        cap_d.delete();
        cap_l.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int pos;
        int c;
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        tick();
        chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_out_data", out_data_o, 32'd0);
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_out_last", 32'(out_last_o), 32'd0);
        chk("rst_in_ready", 32'(in_ready_o), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready_o), 32'd1);
        tick();

        // Full group at full rate
        clear_cap();
        out_ready = 1'b1;
        wv = '{32'd7, 32'd3, 32'd9, 32'd3, 32'd1, 32'd0, 32'd0, 32'd0};
        send(wv, 5, 1'b0);
        drain(5, 5'b11111);
        if (DESC) exv = '{32'd9, 32'd7, 32'd3, 32'd3, 32'd1, 32'd0, 32'd0, 32'd0};
        else      exv = '{32'd1, 32'd3, 32'd3, 32'd7, 32'd9, 32'd0, 32'd0, 32'd0};
        check_seq("full_seq", exv, 5);
        if (cap_l.size() == 5) begin
            for (int i = 0; i < 5; i++) chk("full_last_flag", 32'(cap_l[i]), 32'(i == 4));
        end
        tick();

        // Short group, unsigned extremes
        clear_cap();
        wv = '{32'hFFFF_FFFF, 32'h0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        send(wv, 2, 1'b1);
        drain(2, 5'b11111);
        if (DESC) exv = '{32'hFFFF_FFFF, 32'h0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        else      exv = '{32'h0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        check_seq("short_seq", exv, 2);
        if (cap_l.size() == 2) chk("short_last", 32'(cap_l[1]), 32'd1);
        tick();

        // Backpressure pattern 0,1,0,0,1
        clear_cap();
        wv = '{32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0};
        send(wv, 5, 1'b0);
        drain(5, 5'b10010);
        if (DESC) exv = '{32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0};
        else      exv = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0, 32'd0, 32'd0};
        check_seq("bp_seq", exv, 5);
        tick();

        // Word offered during DRAIN waits for the next group
        clear_cap();
        wv = '{32'd30, 32'd10, 32'd50, 32'd20, 32'd40, 32'd0, 32'd0, 32'd0};
        send(wv, 5, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'd42;
        in_last  = 1'b1;
        acc = 1'b0;
        pos = -1;
        c   = 0;
        while (!acc && c < 100) begin
            out_ready = 1'b1;
            @(negedge clk);
            if (in_ready_o) begin
                acc = 1'b1;
                pos = cap_d.size();
            end
            tick();
            c++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("hold_accept_pos", 32'(pos), 32'd5);
        drain(6, 5'b11111);
        if (DESC) exv = '{32'd50, 32'd40, 32'd30, 32'd20, 32'd10, 32'd42, 32'd0, 32'd0};
        else      exv = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd42, 32'd0, 32'd0};
        check_seq("hold_seq", exv, 6);
        tick();

        // Reset after two drained words
        clear_cap();
        wv = '{32'd11, 32'd44, 32'd22, 32'd55, 32'd33, 32'd0, 32'd0, 32'd0};
        send(wv, 5, 1'b0);
        out_ready = 1'b1;
        c = 0;
        while (cap_d.size() < 2 && c < 50) begin
            tick();
            c++;
        end
        rst       = 1'b1;
        out_ready = 1'b0;
        if (DESC) exv = '{32'd55, 32'd44, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        else      exv = '{32'd11, 32'd22, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        check_seq("pre_rst_seq", exv, 2);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready_o), 32'd1);
        tick();
        clear_cap();
        wv = '{32'd8, 32'd6, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        send(wv, 2, 1'b1);
        drain(2, 5'b11111);
        if (DESC) exv = '{32'd8, 32'd6, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        else      exv = '{32'd6, 32'd8, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        check_seq("post_rst_seq", exv, 2);

        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
